// File: rtl/key_event_classifier_pkg.sv
// Shared definitions for the key event classifier: state encodings, default
// 50 MHz timing constants and a counter-width helper.
package key_event_classifier_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRESS1    = 3'd1;
    localparam logic [2:0] S_WAIT2     = 3'd2;
    localparam logic [2:0] S_PRESS2    = 3'd3;
    localparam logic [2:0] S_LONG_HOLD = 3'd4;

    localparam int unsigned DEF_LONG_CNT    = 75_000_000;
    localparam int unsigned DEF_DBL_GAP_CNT = 15_000_000;
    localparam int unsigned DEF_REPEAT_CNT  = 10_000_000;
    localparam int          DEF_CNT_W       = 27;

    function automatic bit cnt_fits(input int unsigned value, input int width);
        return (longint'(value) < (longint'(1) << width));
    endfunction

endpackage

// File: rtl/key_event_classifier_edge_det.sv
// Registered key level plus fall/rise strobes; key_d resets high (key released)
// so a key held through reset shows a single fall on the first cycle.
module key_edge_det (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic fall,
    output logic rise
);

    logic key_d_reg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            key_d_reg <= 1'b1;
        end else begin
            key_d_reg <= key_in;
        end
    end

    assign fall = key_d_reg & ~key_in;
    assign rise = ~key_d_reg & key_in;

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key presses into short press, double click, long press
// and auto-repeat single-cycle pulses.
module key_event_classifier
    import key_event_classifier_pkg::*;
#(
    parameter int unsigned LONG_CNT    = DEF_LONG_CNT,
    parameter int unsigned DBL_GAP_CNT = DEF_DBL_GAP_CNT,
    parameter int unsigned REPEAT_CNT  = DEF_REPEAT_CNT,
    parameter int          CNT_W       = DEF_CNT_W
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_db,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    if (!cnt_fits(LONG_CNT, CNT_W) || !cnt_fits(DBL_GAP_CNT, CNT_W) ||
        !cnt_fits(REPEAT_CNT, CNT_W)) begin : g_cnt_w_check
        $error("key_event_classifier: CNT_W too narrow for count parameters");
    end
    if (LONG_CNT < 2 || DBL_GAP_CNT < 2 || REPEAT_CNT < 1) begin : g_min_check
        $error("key_event_classifier: count parameters below minimum");
    end

    // Pulses are registered, so the long/gap decisions are taken one cycle
    // early: the pulse then lands exactly LONG_CNT / DBL_GAP_CNT cycles after
    // the edge. Repeat is measured from the long_press cycle itself.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 2);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 2);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             key_fall;
    logic             key_rise;
    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             armed_reg;
    logic             short_reg, short_next;
    logic             double_reg, double_next;
    logic             long_reg, long_next;
    logic             repeat_reg, repeat_next;
    logic             busy_reg;

    key_edge_det u_edge_det (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_in  (key_db),
        .fall    (key_fall),
        .rise    (key_rise)
    );

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_inc;
        short_next  = 1'b0;
        double_next = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (key_fall && armed_reg) begin
                    state_next = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (key_rise) begin
                    state_next = S_WAIT2;
                    cnt_next   = '0;
                end else if (!key_db && cnt_reg == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = S_LONG_HOLD;
                    cnt_next   = '0;
                end
            end
            S_WAIT2: begin
                // A second press beats a coincident gap timeout
                if (key_fall) begin
                    state_next = S_PRESS2;
                    cnt_next   = '0;
                end else if (cnt_reg == GAP_LAST) begin
                    short_next = 1'b1;
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            S_PRESS2: begin
                if (key_rise) begin
                    double_next = 1'b1;
                    state_next  = S_IDLE;
                    cnt_next    = '0;
                end else if (!key_db && cnt_reg == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = S_LONG_HOLD;
                    cnt_next   = '0;
                end
            end
            S_LONG_HOLD: begin
                if (key_rise) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == REP_LAST) begin
                    repeat_next = 1'b1;
                    cnt_next    = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            armed_reg  <= 1'b0;
            short_reg  <= 1'b0;
            double_reg <= 1'b0;
            long_reg   <= 1'b0;
            repeat_reg <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            if (key_db) begin
                armed_reg <= 1'b1;
            end
            short_reg  <= short_next;
            double_reg <= double_next;
            long_reg   <= long_next;
            repeat_reg <= repeat_next;
            busy_reg   <= (state_next != S_IDLE);
        end
    end

    assign short_press  = short_reg;
    assign double_click = double_reg;
    assign long_press   = long_reg;
    assign repeat_pulse = repeat_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_key_event_classifier.sv
// Self-checking bench: table of key sequences with expected pulse cycles fed
// into a scoreboard queue, plus hand-written reset corner cases.
module tb_key_event_classifier;

    localparam int K_SHORT  = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_LONG   = 3;
    localparam int K_REPEAT = 4;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_db  = 1'b1;
    logic short_press, double_click, long_press, repeat_pulse, busy;

    always #5 sys_clk = ~sys_clk;

    key_event_classifier #(
        .LONG_CNT    (20),
        .DBL_GAP_CNT (10),
        .REPEAT_CNT  (5),
        .CNT_W       (8)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_db       (key_db),
        .short_press  (short_press),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .busy         (busy)
    );

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    typedef struct {
        int              low1;
        int              gap;
        int              low2;
        int              n_exp;
        logic [3:0][2:0] kind;
        logic [3:0][7:0] off;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    int   n_hot;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_SHORT:  return "short_press";
            K_DOUBLE: return "double_click";
            K_LONG:   return "long_press";
            K_REPEAT: return "repeat_pulse";
            default:  return "none";
        endcase
    endfunction

    function automatic vec_t mk(input int low1, input int gap, input int low2, input int n,
                                input int k0, input int o0, input int k1, input int o1,
                                input int k2, input int o2, input int k3, input int o3);
        vec_t v;
        v.low1 = low1; v.gap = gap; v.low2 = low2; v.n_exp = n;
        v.kind[0] = 3'(k0); v.off[0] = 8'(o0);
        v.kind[1] = 3'(k1); v.off[1] = 8'(o1);
        v.kind[2] = 3'(k2); v.off[2] = 8'(o2);
        v.kind[3] = 3'(k3); v.off[3] = 8'(o3);
        return v;
    endfunction

    task automatic check_val(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_pulse(input logic p, input int k);
        exp_t e;
        if (p) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got %s at cycle %0d, expected no pulse", kname(k), cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != k || e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL pulse_match: got %s at cycle %0d, expected %s at cycle %0d",
                             kname(k), cyc, kname(e.kind), e.cyc);
                end
            end
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge sys_clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missed_pulse: got nothing at cycle %0d, expected %s",
                         exp_q[0].cyc, kname(exp_q[0].kind));
                void'(exp_q.pop_front());
            end
            n_hot = int'(short_press) + int'(double_click) + int'(long_press);
            if (n_hot > 0) check_val("event_exclusive", n_hot, 1);
            check_pulse(short_press, K_SHORT);
            check_pulse(double_click, K_DOUBLE);
            check_pulse(long_press, K_LONG);
            check_pulse(repeat_pulse, K_REPEAT);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic drain_check(input string name);
        check_val(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   n0;
        exp_t e;
        n0 = cyc;
        for (int i = 0; i < v.n_exp; i++) begin
            e.kind = int'(v.kind[i]);
            e.cyc  = n0 + int'(v.off[i]);
            exp_q.push_back(e);
        end
        key_db = 1'b0;
        step(v.low1);
        key_db = 1'b1;
        if (v.low2 > 0) begin
            step(v.gap);
            key_db = 1'b0;
            step(v.low2);
            key_db = 1'b1;
        end
        step(40);
        $display("[TB] vec %0d: low1=%0d gap=%0d low2=%0d expected_events=%0d pending=%0d",
                 idx, v.low1, v.gap, v.low2, v.n_exp, exp_q.size());
        drain_check("vec_pending");
    endtask

    initial begin
        exp_t e;
        int   n0;
        vecs[0] = mk(5,  0,  0, 1, K_SHORT, 15, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(4,  3,  4, 1, K_DOUBLE, 12, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(37, 0,  0, 4, K_LONG, 20, K_REPEAT, 25, K_REPEAT, 30, K_REPEAT, 35);
        vecs[3] = mk(3,  9,  3, 1, K_DOUBLE, 16, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(3, 10,  3, 2, K_SHORT, 13, K_SHORT, 26, 0, 0, 0, 0);
        vecs[5] = mk(19, 0,  0, 1, K_SHORT, 29, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(20, 0,  0, 1, K_LONG, 20, 0, 0, 0, 0, 0, 0);
        vecs[7] = mk(3,  3, 24, 1, K_LONG, 26, 0, 0, 0, 0, 0, 0);

        // Reset state
        sys_rst = 1'b1;
        key_db  = 1'b1;
        step(3);
        check_val("reset_outputs",
                  int'({short_press, double_click, long_press, repeat_pulse}), 0);
        check_val("reset_busy", int'(busy), 0);
        sys_rst = 1'b0;
        step(3);
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // busy drops in the same cycle short_press fires
        n0 = cyc;
        e.kind = K_SHORT; e.cyc = n0 + 15;
        exp_q.push_back(e);
        key_db = 1'b0;
        step(5);
        key_db = 1'b1;
        step(9);
        check_val("busy_before_short", int'(busy), 1);
        step(1);
        check_val("busy_at_short", int'(busy), 0);
        step(20);
        $display("[TB] busy timing sequence done");
        drain_check("busy_seq_pending");

        // Key held low through reset release: nothing until a fresh press
        key_db  = 1'b0;
        sys_rst = 1'b1;
        step(2);
        sys_rst = 1'b0;
        step(30);
        check_val("held_reset_busy", int'(busy), 0);
        key_db = 1'b1;
        step(5);
        check_val("held_reset_release_busy", int'(busy), 0);
        $display("[TB] held-through-reset sequence done");
        drain_check("held_reset_pending");
        run_vec(8, mk(3, 0, 0, 1, K_SHORT, 13, 0, 0, 0, 0, 0, 0));

        // Reset in the middle of WAIT2 aborts the pending short press
        key_db = 1'b0;
        step(3);
        key_db = 1'b1;
        step(4);
        check_val("wait2_busy", int'(busy), 1);
        sys_rst = 1'b1;
        #1;
        check_val("async_reset_busy", int'(busy), 0);
        check_val("async_reset_outputs",
                  int'({short_press, double_click, long_press, repeat_pulse}), 0);
        step(2);
        sys_rst = 1'b0;
        step(25);
        $display("[TB] mid-WAIT2 reset sequence done");
        drain_check("mid_reset_pending");

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
